// File: rtl/pipelined_logic_cone_pkg.sv
// Shared definitions for the pipelined logic cone: mode encodings, level
// operator selection and single-node evaluation.
package pipelined_logic_cone_pkg;

   localparam logic MODE_NANDNOR = 1'b0;
   localparam logic MODE_XOR     = 1'b1;

   typedef enum logic [1:0] {
      OP_NAND,
      OP_NOR,
      OP_XOR
   } level_op_e;

   // Operator applied at a given tree level for a given transaction mode.
   function automatic level_op_e level_op(input logic mode, input int unsigned level);
      if (mode == MODE_XOR) begin
         return OP_XOR;
      end
      return (level % 2 == 0) ? OP_NAND : OP_NOR;
   endfunction

   // Two-input node of the reduction tree.
   function automatic logic node_eval(input level_op_e op, input logic a, input logic b);
      case (op)
         OP_NAND: return ~(a & b);
         OP_NOR:  return ~(a | b);
         default: return a ^ b;
      endcase
   endfunction

endpackage

// File: rtl/pipelined_logic_cone_level.sv
// One tree level: evaluates NUM_NODES nodes per channel from the previous
// level's 2*NUM_NODES nodes and registers them with their valid and mode bits.
module logic_cone_level
   import pipelined_logic_cone_pkg::*;
#(
   parameter int          NUM_NODES = 8,
   parameter int          NUM_CH    = 2,
   parameter int unsigned LEVEL     = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          adv,
   input  logic                          prev_valid,
   input  logic                          prev_mode,
   input  logic [NUM_CH*2*NUM_NODES-1:0] prev_data,
   output logic                          stage_valid,
   output logic                          stage_mode,
   output logic [NUM_CH*NUM_NODES-1:0]   stage_data
);

   logic                        valid_d, valid_q;
   logic                        mode_d,  mode_q;
   logic [NUM_CH*NUM_NODES-1:0] data_d,  data_q;
   logic [NUM_CH*NUM_NODES-1:0] node_vec;

   // Evaluate this level's nodes and choose between loading and holding.
   always_comb begin
      level_op_e op;
      // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
      op       = level_op(prev_mode, LEVEL);
      node_vec = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         for (int i = 0; i < NUM_NODES; i++) begin
            node_vec[c*NUM_NODES + i] = node_eval(op,
                                                  prev_data[c*2*NUM_NODES + 2*i],
                                                  prev_data[c*2*NUM_NODES + 2*i + 1]);
         end
      end
      valid_d = valid_q;
      mode_d  = mode_q;
      data_d  = data_q;
      if (adv) begin
         valid_d = prev_valid;
         mode_d  = prev_mode;
         data_d  = node_vec;
      end
   end

   // Stage register; a load with prev_valid=0 inserts a bubble.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) begin
         valid_q <= 1'b0;
         mode_q  <= MODE_NANDNOR;
         // NOTE: data is cleared too, so out_data is never undefined after reset.
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         mode_q  <= mode_d;
         data_q  <= data_d;
      end
   end

   assign stage_valid = valid_q;
   assign stage_mode  = mode_q;
   assign stage_data  = data_q;

endmodule

// File: rtl/pipelined_logic_cone.sv
// NUM_CH balanced reduction trees over NUM_IN bits each, one register stage
// per tree level, valid/ready flow control and a completed-result counter.
module pipelined_logic_cone
   import pipelined_logic_cone_pkg::*;
#(
   parameter int NUM_IN = 16,
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_mode,
   input  logic [NUM_CH*NUM_IN-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NUM_CH-1:0]        out_data,
   output logic [CNT_W-1:0]         out_count
);

   localparam int LEVELS = $clog2(NUM_IN);
   // Input vector followed by every stage's node vector, narrowest last.
   localparam int BUS_W  = NUM_CH * (2*NUM_IN - 1);

   logic [BUS_W-1:0]  node_bus;
   logic [LEVELS:0]   valid_chain;
   logic [LEVELS:0]   mode_chain;
   logic [LEVELS-1:0] stage_adv;
   logic [CNT_W-1:0]  count_d, count_q;
   logic              unused_last_mode;

   assign node_bus[NUM_CH*NUM_IN-1:0] = in_data;
   assign valid_chain[0]              = in_valid;
   assign mode_chain[0]               = in_mode;

   // Advance ripples from the output: a stage moves if empty or if its successor moves.
   always_comb begin
      logic ready_down;
      ready_down = out_ready;
      stage_adv  = '0;
      for (int k = LEVELS-1; k >= 0; k--) begin
         stage_adv[k] = ~valid_chain[k+1] | ready_down;
         ready_down   = stage_adv[k];
      end
   end

   generate
      for (genvar k = 0; k < LEVELS; k++) begin : g_stage
         localparam int NN      = NUM_IN >> (k+1);
         localparam int IN_OFF  = NUM_CH * (2*NUM_IN - 4*NN);
         localparam int OUT_OFF = NUM_CH * (2*NUM_IN - 2*NN);

         logic_cone_level #(
            .NUM_NODES (NN),
            .NUM_CH    (NUM_CH),
            .LEVEL     (k)
         ) u_level (
            .clk         (clk),
            .rst         (rst),
            .adv         (stage_adv[k]),
            .prev_valid  (valid_chain[k]),
            .prev_mode   (mode_chain[k]),
            .prev_data   (node_bus[IN_OFF +: NUM_CH*2*NN]),
            .stage_valid (valid_chain[k+1]),
            .stage_mode  (mode_chain[k+1]),
            .stage_data  (node_bus[OUT_OFF +: NUM_CH*NN])
         );
      end
   endgenerate

   // The final stage's mode has no consumer once the tree is fully reduced.
   assign unused_last_mode = mode_chain[LEVELS];

   assign in_ready  = stage_adv[0];
   assign out_valid = valid_chain[LEVELS];
   assign out_data  = node_bus[BUS_W-1 -: NUM_CH];

   // Count output handshakes, wrapping naturally at 2^CNT_W.
   always_comb begin
      count_d = count_q;
      if (out_valid && out_ready) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // Result counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign out_count = count_q;

endmodule

// File: tb/tb_pipelined_logic_cone.sv
// Scoreboard bench for pipelined_logic_cone (NUM_IN=16, NUM_CH=2, CNT_W=8).
module tb_pipelined_logic_cone;

   localparam int NUM_IN = 16;
   localparam int NUM_CH = 2;
   localparam int CNT_W  = 8;

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic                     in_valid = 1'b0;
   logic                     in_ready;
   logic                     in_mode = 1'b0;
   logic [NUM_CH*NUM_IN-1:0] in_data = '0;
   logic                     out_valid;
   logic                     out_ready = 1'b1;
   logic [NUM_CH-1:0]        out_data;
   logic [CNT_W-1:0]         out_count;

   typedef struct {
      logic [1:0] d;
      int         acc;
      bit         lat;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_total = 0;
   int   n_bad   = 0;
   int   cyc     = 0;

   pipelined_logic_cone #(
      .NUM_IN (NUM_IN),
      .NUM_CH (NUM_CH),
      .CNT_W  (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mode   (in_mode),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_count (out_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Closed form for LEVELS=4 (even): mode 0 is AND, mode 1 is XOR per channel.
   function automatic logic [1:0] model(input logic m, input logic [31:0] d);
      logic [1:0] r;
      for (int c = 0; c < NUM_CH; c++) begin
         r[c] = m ? ^d[c*NUM_IN +: NUM_IN] : &d[c*NUM_IN +: NUM_IN];
      end
      return r;
   endfunction

   function automatic logic [31:0] stim_data(input int i);
      if (i % 2 == 1) return 32'h1357_0003 ^ (i * 32'h0001_0001);
      if (i % 4 == 0) return 32'hFFFF_FFFF;
      return 32'hFFFF_FFFF ^ (32'h1 << (i % 32));
   endfunction

   // Called at a negedge; offers one transaction and returns at the negedge after acceptance.
   task automatic send(input logic m, input logic [31:0] d, input logic [1:0] exp,
                       input bit lat, input bit chk_rdy);
      int t;
      exp_t e;
      in_valid = 1'b1;
      in_mode  = m;
      in_data  = d;
      #1;
      if (chk_rdy) check("in_ready_stream", in_ready, 1);
      t = 0;
      while (!in_ready) begin
         @(negedge clk);
         #1;
         t++;
         if (t > 50) begin
            n_total++;
            n_bad++;
            $display("FAIL send_timeout: got=in_ready 0 expected=1 within 50 cycles");
            return;
         end
      end
      e.d   = exp;
      e.acc = cyc;
      e.lat = lat;
      sb.push_back(e);
      @(negedge clk);
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_data  = '0;
      in_mode  = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0) begin
         @(negedge clk);
         t++;
         if (t > 200) begin
            n_total++;
            n_bad++;
            $display("FAIL drain_timeout: got=%0d pending expected=0", sb.size());
            sb.delete();
         end
      end
      @(negedge clk);
   endtask

   // Called at a negedge; one reset cycle, discarding all expectations in flight.
   task automatic do_reset();
      idle();
      rst = 1'b1;
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Monitor: compare whenever an output handshake is about to happen.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_total++;
               n_bad++;
               $display("FAIL unexpected_output: got=%b expected=none", out_data);
            end else begin
               mon_e = sb.pop_front();
               check("out_data", out_data, mon_e.d);
               if (mon_e.lat) check("latency", cyc, mon_e.acc + 4);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data",  out_data,  0);
      check("rst_out_count", out_count, 0);
      check("rst_in_ready",  in_ready,  1);
      @(negedge clk);

      // Basic AND and parity.
      send(1'b0, 32'hFFFF_FFFF, 2'b11, 1, 1);
      send(1'b0, 32'hFFFF_FFFE, 2'b10, 1, 1);
      send(1'b1, 32'h0001_0003, 2'b10, 1, 1);
      send(1'b1, 32'h0003_0001, 2'b01, 1, 1);
      idle();
      drain();
      check("count_basic", out_count, 4);

      // Streaming, alternating modes.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         send(i[0], stim_data(i), model(i[0], stim_data(i)), 1, 1);
      end
      idle();
      drain();
      check("count_stream", out_count, 20);

      // Backpressure: four accepted, fifth offered during a 10-cycle stall.
      out_ready = 1'b0;
      send(1'b0, 32'hFFFF_FFFF, 2'b11, 0, 0);
      send(1'b0, 32'hFFFF_FFFE, 2'b10, 0, 0);
      send(1'b0, 32'hFFFE_FFFF, 2'b01, 0, 0);
      send(1'b0, 32'h0000_0000, 2'b00, 0, 0);
      in_valid = 1'b1;
      in_mode  = 1'b1;
      in_data  = 32'h0001_0003;
      for (int i = 0; i < 10; i++) begin
         #1;
         check("stall_in_ready",  in_ready,  0);
         check("stall_out_valid", out_valid, 1);
         check("stall_out_data",  out_data,  2'b11);
         @(negedge clk);
      end
      out_ready = 1'b1;
      send(1'b1, 32'h0001_0003, 2'b10, 0, 1);
      send(1'b1, 32'h0003_0001, 2'b01, 0, 1);
      idle();
      drain();
      check("count_backpressure", out_count, 26);

      // Counter wrap.
      do_reset();
      for (int i = 0; i < 257; i++) begin
         send(i[0], stim_data(i), model(i[0], stim_data(i)), 1, 1);
      end
      idle();
      drain();
      check("count_wrap", out_count, 1);

      // Mid-flight reset with three transactions in flight.
      send(1'b0, 32'hFFFF_FFFF, 2'b11, 0, 1);
      send(1'b1, 32'h0001_0003, 2'b10, 0, 1);
      send(1'b0, 32'hFFFF_FFFE, 2'b10, 0, 1);
      do_reset();
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_out_count", out_count, 0);
      check("midrst_in_ready",  in_ready,  1);
      repeat (8) @(negedge clk);
      #1;
      check("midrst_no_stale", out_valid, 0);
      @(negedge clk);
      send(1'b1, 32'h8000_0001, 2'b11, 1, 1);
      idle();
      drain();
      check("count_after_rst", out_count, 1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
